// File: rtl/waterbear_pkg.sv
// Shared definitions for the waterbear core and its program loader:
// opcode values, instruction field positions, loader state encoding.
package waterbear_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned ADDR_W = 8;

  localparam logic [3:0] OP_LDR = 4'd1;
  localparam logic [3:0] OP_STR = 4'd2;
  localparam logic [3:0] OP_ADD = 4'd3;
  localparam logic [3:0] OP_SUB = 4'd4;
  localparam logic [3:0] OP_EQU = 4'd5;
  localparam logic [3:0] OP_JMP = 4'd6;
  localparam logic [3:0] OP_HLT = 4'd7;

  localparam int unsigned RSV_MSB     = 15;
  localparam int unsigned RSV_LSB     = 11;
  localparam int unsigned OPC_MSB     = 10;
  localparam int unsigned OPC_LSB     = 7;
  localparam int unsigned NUMBIT_POS  = 6;
  localparam int unsigned OPND_MSB    = 5;
  localparam int unsigned OPND_LSB    = 0;

  localparam logic [BYTE_W-1:0] SYNC_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_CNT   = 4'd1,
    ST_BASE  = 4'd2,
    ST_HI    = 4'd3,
    ST_LO    = 4'd4,
    ST_WR    = 4'd5,
    ST_CHK   = 4'd6,
    ST_DONE  = 4'd7,
    ST_ERROR = 4'd8
  } loader_state_e;

endpackage

// File: rtl/waterbear_insn_check.sv
// Combinational instruction-format check: reserved field clear and a defined
// opcode. Shared with the core's decoder.
module waterbear_insn_check
  import waterbear_pkg::*;
(
  input  logic [WORD_W-1:0] i_word,
  output logic              o_valid
);

  logic [3:0] w_opcode;
  logic       w_rsv_clear;
  logic       w_op_known;
  logic [6:0] w_unused_operand;

  assign w_opcode         = i_word[OPC_MSB:OPC_LSB];
  assign w_rsv_clear      = (i_word[RSV_MSB:RSV_LSB] == '0);
  assign w_unused_operand = {i_word[NUMBIT_POS], i_word[OPND_MSB:OPND_LSB]};

  always_comb begin
    w_op_known = 1'b0;
    case (w_opcode)
      OP_LDR, OP_STR, OP_ADD, OP_SUB, OP_EQU, OP_JMP, OP_HLT: w_op_known = 1'b1;
      default: w_op_known = 1'b0;
    endcase
  end

  assign o_valid = w_rsv_clear && w_op_known;

endmodule

// File: rtl/waterbear_loader.sv
// Byte-stream program loader for the waterbear instruction memory; holds the
// core in reset until a complete, valid image lands. Optional CHK byte is
// enabled by defining WATERBEAR_LOADER_CHECKSUM_EN.
module waterbear_loader
  import waterbear_pkg::*;
#(
  parameter logic [BYTE_W-1:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              err_clr,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              error
);

  loader_state_e r_state;
  loader_state_e w_next;

  logic              r_live;
  logic [BYTE_W-1:0] r_count;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_idx;
  logic [BYTE_W-1:0] r_hi;
  logic              r_word_ok;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [WORD_W-1:0] r_mem_wdata;
  logic              r_cpu_rst;
  logic              r_done;
  logic              r_error;
`ifdef WATERBEAR_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] r_chk;
`endif

  logic              w_state_rdy;
  logic              w_fire;
  logic              w_last;
  logic [WORD_W-1:0] w_word;
  logic              w_word_ok;

  // r_live keeps in_ready low until the first clock after reset release
  assign in_ready = r_live && w_state_rdy;
  assign w_fire   = in_valid && in_ready;
  assign w_word   = {r_hi, in_data};
  // COUNT of 0 wraps to 255 here, giving 256 words
  assign w_last   = (r_idx == ADDR_W'(r_count - BYTE_W'(1)));

  waterbear_insn_check u_insn_check (
    .i_word  (w_word),
    .o_valid (w_word_ok)
  );

  always_comb begin
    w_state_rdy = 1'b0;
    case (r_state)
      ST_IDLE, ST_CNT, ST_BASE, ST_HI, ST_LO, ST_CHK: w_state_rdy = 1'b1;
      default: w_state_rdy = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_fire && (in_data == SYNC_BYTE)) w_next = ST_CNT;
      ST_CNT:   if (w_fire) w_next = ST_BASE;
      ST_BASE:  if (w_fire) w_next = ST_HI;
      ST_HI:    if (w_fire) w_next = ST_LO;
      ST_LO:    if (w_fire) w_next = ST_WR;
      ST_WR: begin
        if (!r_word_ok)  w_next = ST_ERROR;
`ifdef WATERBEAR_LOADER_CHECKSUM_EN
        else if (w_last) w_next = ST_CHK;
`else
        else if (w_last) w_next = ST_DONE;
`endif
        else             w_next = ST_HI;
      end
`ifdef WATERBEAR_LOADER_CHECKSUM_EN
      ST_CHK:   if (w_fire) w_next = (in_data == r_chk) ? ST_DONE : ST_ERROR;
`endif
      ST_DONE:  w_next = ST_IDLE;
      ST_ERROR: if (err_clr) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Datapath and registered outputs; status outputs track the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_live      <= 1'b0;
      r_count     <= '0;
      r_base      <= '0;
      r_idx       <= '0;
      r_hi        <= '0;
      r_word_ok   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_cpu_rst   <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
`ifdef WATERBEAR_LOADER_CHECKSUM_EN
      r_chk       <= '0;
`endif
    end else begin
      r_live    <= 1'b1;
      r_mem_we  <= 1'b0;
      r_done    <= (w_next == ST_DONE);
      r_error   <= (w_next == ST_ERROR);
      r_cpu_rst <= (w_next != ST_IDLE) && (w_next != ST_DONE);
      case (r_state)
        ST_IDLE: if (w_fire && (in_data == SYNC_BYTE)) begin
          r_idx <= '0;
`ifdef WATERBEAR_LOADER_CHECKSUM_EN
          r_chk <= '0;
`endif
        end
        ST_CNT: if (w_fire) begin
          r_count <= in_data;
`ifdef WATERBEAR_LOADER_CHECKSUM_EN
          r_chk   <= r_chk ^ in_data;
`endif
        end
        ST_BASE: if (w_fire) begin
          r_base <= in_data;
`ifdef WATERBEAR_LOADER_CHECKSUM_EN
          r_chk  <= r_chk ^ in_data;
`endif
        end
        ST_HI: if (w_fire) begin
          r_hi  <= in_data;
`ifdef WATERBEAR_LOADER_CHECKSUM_EN
          r_chk <= r_chk ^ in_data;
`endif
        end
        ST_LO: if (w_fire) begin
          r_word_ok <= w_word_ok;
`ifdef WATERBEAR_LOADER_CHECKSUM_EN
          r_chk     <= r_chk ^ in_data;
`endif
          // write strobe lands in the WR cycle
          if (w_word_ok) begin
            r_mem_we    <= 1'b1;
            r_mem_addr  <= r_base + r_idx;
            r_mem_wdata <= w_word;
          end
        end
        ST_WR: if (r_word_ok) r_idx <= r_idx + ADDR_W'(1);
        default: ;
      endcase
    end
  end

  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign cpu_rst   = r_cpu_rst;
  assign done      = r_done;
  assign error     = r_error;

endmodule

// File: tb/tb_waterbear_loader.sv
// Self-checking bench for waterbear_loader: directed frame table, reset and
// idle corner cases, and random frames against a frame-level reference model.
module tb_waterbear_loader;

  localparam logic [7:0] SYNC = 8'hA5;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        err_clr;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        cpu_rst;
  logic        done;
  logic        error;

  always #5 clk = ~clk;

  waterbear_loader dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .err_clr   (err_clr),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_rst   (cpu_rst),
    .done      (done),
    .error     (error)
  );

  typedef struct {
    logic [7:0]  a;
    logic [15:0] d;
  } wr_t;

  typedef struct {
    string       name;
    logic [7:0]  count;
    logic [7:0]  base;
    logic [15:0] w0;
    logic [15:0] w1;
    logic [15:0] w2;
    logic [7:0]  flip;
    bit          gaps;
    int          exp_writes;
    int          exp_done;
  } vec_t;

  int vectors = 0;
  int miscompares = 0;

  wr_t         mon_q[$];
  int          done_cnt;
  int          done_bad;
  int          we_bad;
  logic        prev_cpu_rst = 1'b0;
  logic [15:0] wq[$];

  // Capture writes and done pulses just after each rising edge
  always @(posedge clk) begin
    #1;
    if (mem_we === 1'b1) begin
      mon_q.push_back('{mem_addr, mem_wdata});
      if (cpu_rst !== 1'b1) we_bad++;
    end
    if (done === 1'b1) begin
      done_cnt++;
      if (cpu_rst !== 1'b0 || prev_cpu_rst !== 1'b1) done_bad++;
    end
    prev_cpu_rst = cpu_rst;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic bit insn_ok(input logic [15:0] w);
    int op;
    op = int'(w[10:7]);
    return (w[15:11] == 5'd0) && (op >= 1) && (op <= 7);
  endfunction

  // Called just after a falling edge; returns just after the falling edge
  // following the rising edge that transferred the byte.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int guard;
    guard = 0;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        err_clr  = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      err_clr = 1'b0;
    end
    in_data  = b;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("ready_timeout", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Sends one frame built from wq and checks it against the frame rules.
  task automatic run_frame(input string nm, input logic [7:0] count, input logic [7:0] base,
                           input logic [7:0] flip, input bit gaps);
    wr_t        exp_q[$];
    bit         err;
    logic [7:0] chk;
    int         n;
    err = 1'b0;
    mon_q.delete();
    done_cnt = 0;
    done_bad = 0;
    we_bad   = 0;
    n = (count == 8'd0) ? 256 : int'(count);
    send_byte(SYNC, gaps);
    send_byte(count, gaps);
    send_byte(base, gaps);
    chk = count ^ base;
    for (int k = 0; k < n; k++) begin
      send_byte(wq[k][15:8], gaps);
      send_byte(wq[k][7:0], gaps);
      chk = chk ^ wq[k][15:8] ^ wq[k][7:0];
      if (!insn_ok(wq[k])) begin
        err = 1'b1;
        break;
      end
      exp_q.push_back('{8'(int'(base) + k), wq[k]});
    end
`ifdef WATERBEAR_LOADER_CHECKSUM_EN
    if (!err) begin
      send_byte(chk ^ flip, gaps);
      if (flip != 8'd0) err = 1'b1;
    end
`else
    if (flip != 8'd0 && chk == 8'd0) err = err;
`endif
    for (int c = 0; c < 20; c++) begin
      if (done_cnt != 0 || error === 1'b1) break;
      @(negedge clk);
    end
    check({nm, " nwrites"}, 32'(mon_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
      check($sformatf("%s addr%0d", nm, i), 32'(mon_q[i].a), 32'(exp_q[i].a));
      check($sformatf("%s data%0d", nm, i), 32'(mon_q[i].d), 32'(exp_q[i].d));
    end
    check({nm, " done"}, 32'(done_cnt), err ? 32'd0 : 32'd1);
    check({nm, " error"}, 32'(error), 32'(err));
    check({nm, " cpu_rst"}, 32'(cpu_rst), 32'(err));
    check({nm, " done_cpu_rst_edge"}, 32'(done_bad), 32'd0);
    check({nm, " we_under_cpu_rst"}, 32'(we_bad), 32'd0);
    if (err) begin
      check({nm, " ready_in_error"}, 32'(in_ready), 32'd0);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      check({nm, " error_cleared"}, 32'(error), 32'd0);
      check({nm, " ready_after_clr"}, 32'(in_ready), 32'd1);
    end else begin
      @(negedge clk);
      check({nm, " ready_idle"}, 32'(in_ready), 32'd1);
    end
  endtask

  task automatic load_vec(input vec_t v);
    wq.delete();
    if (v.count >= 8'd1) wq.push_back(v.w0);
    if (v.count >= 8'd2) wq.push_back(v.w1);
    if (v.count >= 8'd3) wq.push_back(v.w2);
  endtask

  vec_t tab[9];

  initial begin
    tab[0] = '{"basic",     8'h03, 8'h10, 16'h00C5, 16'h010F, 16'h0380, 8'h00, 1'b0, 3, 1};
    tab[1] = '{"wrap",      8'h03, 8'hFE, 16'h0085, 16'h03FF, 16'h0100, 8'h00, 1'b0, 3, 1};
    tab[2] = '{"rsv_bit",   8'h03, 8'h10, 16'h00C5, 16'h0800, 16'h0380, 8'h00, 1'b0, 1, 0};
    tab[3] = '{"op_zero",   8'h03, 8'h10, 16'h00C5, 16'h0000, 16'h0380, 8'h00, 1'b0, 1, 0};
    tab[4] = '{"op_eight",  8'h02, 8'h40, 16'h0400, 16'h0080, 16'h0000, 8'h00, 1'b0, 0, 0};
`ifdef WATERBEAR_LOADER_CHECKSUM_EN
    tab[5] = '{"bad_chk",   8'h03, 8'h30, 16'h00C5, 16'h010F, 16'h0380, 8'h01, 1'b0, 3, 0};
`else
    tab[5] = '{"bad_chk",   8'h03, 8'h30, 16'h00C5, 16'h010F, 16'h0380, 8'h01, 1'b0, 3, 1};
`endif
    tab[6] = '{"sync_data", 8'h02, 8'hA5, 16'h00A5, 16'h02A5, 16'h0000, 8'h00, 1'b0, 2, 1};
    tab[7] = '{"gaps",      8'h03, 8'h10, 16'h00C5, 16'h010F, 16'h0380, 8'h00, 1'b1, 3, 1};
    tab[8] = '{"single",    8'h01, 8'hFF, 16'h0380, 16'h0000, 16'h0000, 8'h00, 1'b0, 1, 1};

    rst = 1'b1;
    in_data = 8'h00;
    in_valid = 1'b0;
    err_clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst in_ready", 32'(in_ready), 32'd0);
    check("rst mem_we",   32'(mem_we),   32'd0);
    check("rst mem_addr", 32'(mem_addr), 32'd0);
    check("rst mem_wdata",32'(mem_wdata),32'd0);
    check("rst cpu_rst",  32'(cpu_rst),  32'd0);
    check("rst done",     32'(done),     32'd0);
    check("rst error",    32'(error),    32'd0);
    rst = 1'b0;
    #1;
    check("release ready_before_clk", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("release ready_after_clk", 32'(in_ready), 32'd1);

    // Junk bytes in IDLE are dropped
    mon_q.delete();
    send_byte(8'h00, 1'b0);
    send_byte(8'h5A, 1'b0);
    @(negedge clk);
    check("idle_junk ready",   32'(in_ready), 32'd1);
    check("idle_junk cpu_rst", 32'(cpu_rst),  32'd0);
    check("idle_junk error",   32'(error),    32'd0);
    check("idle_junk writes",  32'(mon_q.size()), 32'd0);

    foreach (tab[i]) begin
      load_vec(tab[i]);
      run_frame(tab[i].name, tab[i].count, tab[i].base, tab[i].flip, tab[i].gaps);
      check({tab[i].name, " tab_writes"}, 32'(mon_q.size()), 32'(tab[i].exp_writes));
      check({tab[i].name, " tab_done"},   32'(done_cnt),     32'(tab[i].exp_done));
    end

    // Reset while in LO of the second word
    send_byte(SYNC, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h20, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h85, 1'b0);
    send_byte(8'h01, 1'b0);
    check("midrst cpu_rst_before", 32'(cpu_rst), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("midrst in_ready",  32'(in_ready),  32'd0);
    check("midrst mem_we",    32'(mem_we),    32'd0);
    check("midrst mem_addr",  32'(mem_addr),  32'd0);
    check("midrst mem_wdata", 32'(mem_wdata), 32'd0);
    check("midrst cpu_rst",   32'(cpu_rst),   32'd0);
    check("midrst done",      32'(done),      32'd0);
    check("midrst error",     32'(error),     32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    load_vec(tab[0]);
    run_frame("after_rst", tab[0].count, tab[0].base, 8'h00, 1'b0);

    // Random frames, random pacing, occasional bad words and CHK corruption
    for (int f = 0; f < 24; f++) begin
      logic [7:0] cnt;
      logic [7:0] fl;
      cnt = 8'($urandom_range(1, 8));
      wq.delete();
      for (int k = 0; k < int'(cnt); k++) begin
        if ($urandom_range(0, 7) == 0) wq.push_back(16'($urandom));
        else wq.push_back({5'd0, 4'($urandom_range(1, 7)), 7'($urandom)});
      end
      fl = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
      run_frame($sformatf("rand%0d", f), cnt, 8'($urandom), fl, 1'($urandom_range(0, 1)));
    end

    // COUNT = 0 loads 256 words and wraps over the whole memory
    wq.delete();
    for (int k = 0; k < 256; k++) wq.push_back({5'd0, 4'($urandom_range(1, 7)), 7'($urandom)});
    run_frame("count256", 8'h00, 8'($urandom), 8'h00, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/waterbear_loader.md
# waterbear_loader

Program loader for the waterbear core: receives a byte stream over a valid/ready handshake, assembles 16-bit instruction words, checks each word against the instruction format, and writes it into the core's 256×16 main memory. It is the writer side of the instruction memory that the core fetches from. It holds the core in reset while an image is loaded and releases it only after a complete, valid image.

## Interface
Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts a byte; a transfer occurs on a rising edge where in_valid && in_ready.
- err_clr  in  1  leaves ERROR and returns to IDLE.
- mem_we  out  1  one-cycle write strobe to main memory.
- mem_addr  out  8  write address.
- mem_wdata  out  16  instruction word.
- cpu_rst  out  1  active-high reset to the core.
- done  out  1  one-cycle pulse when a load completes.
- error  out  1  level; high while in ERROR.

## Operation
- Frame format: SYNC_BYTE, COUNT, BASE, then COUNT words sent high byte first, then CHK (only when the checksum feature is compiled in).
- COUNT = 0 means 256 words.
- Word k is written to (BASE + k) mod 256. The address wraps from 0xFF to 0x00.
- States:
  - IDLE: in_ready=1. Bytes other than SYNC_BYTE are dropped. SYNC_BYTE → CNT and asserts cpu_rst.
  - CNT: accept COUNT → BASE.
  - BASE: accept BASE → HI.
  - HI: latch the high byte → LO.
  - LO: latch the low byte → WR.
  - WR: in_ready=0. Check the word.
    - Valid word: mem_we=1. Then, if words remain → HI; if last word → CHK when checksum is enabled, otherwise DONE.
    - Invalid word: no write → ERROR.
  - CHK: accept CHK. Match → DONE; mismatch → ERROR.
  - DONE: done=1, cpu_rst=0 → IDLE.
  - ERROR: in_ready=0, error=1, cpu_rst stays 1. err_clr → IDLE. err_clr is ignored in all other states.
- Word validity:
  - bits[15:11] == 0 (reserved field);
  - bits[10:7] in 1..7 (LDR, STR, ADD, SUB, EQU, JMP, HLT);
  - bits[6:0] are unrestricted.
- A SYNC_BYTE value received mid-frame is data, not a restart.
- Words written before an error remain in memory. cpu_rst stays asserted, so a partial image never executes.
- Reset values: in_ready=0 during rst, then 1 in IDLE from the first clock after release. mem_we=0, mem_addr=0, mem_wdata=0, cpu_rst=0, done=0, error=0. State=IDLE, word counter=0, checksum=0.
- Reset mid-frame: the frame is abandoned, cpu_rst drops to 0, and the core runs whatever memory holds.

## Timing
- One byte per cycle maximum. in_ready is combinational from state only, never from in_valid.
- Word latency: the low byte is accepted at edge t; mem_we/mem_addr/mem_wdata are registered and valid for cycle t+1 only.
- in_ready is low in WR, so each word costs a minimum of 3 cycles.
- cpu_rst rises the cycle after SYNC_BYTE is accepted. It falls in the same cycle that done pulses.
- Minimum frame time at full rate: 3 + 3·N cycles, +1 for CHK, +1 for DONE.

## Configuration
- WATERBEAR_LOADER_CHECKSUM_EN defined:
  - Running XOR over COUNT, BASE and all word bytes, excluding SYNC_BYTE.
  - The CHK byte must equal that XOR; mismatch → ERROR.
- Undefined:
  - No CHK state and no checksum register.
  - DONE follows the last WR directly.

## Structure
- waterbear_pkg holds:
  - opcode constants LDR=1, STR=2, ADD=3, SUB=4, EQU=5, JMP=6, HLT=7;
  - field positions RESERVED[15:11], OPCODE[10:7], NUMBIT[6], OPERAND[5:0];
  - default SYNC_BYTE;
  - the loader state enum.
- Sub-module waterbear_insn_check: combinational, 16-bit word in → valid out. It is reusable by the core's decoder.

## Test plan
- Reset release, then SYNC,0x03,0x10 and words 0x00C5,0x010F,0x0380 with correct CHK → writes at 0x10/0x11/0x12 with those data; cpu_rst high throughout; done pulse with cpu_rst falling the same cycle.
- BASE=0xFE, COUNT=3 → writes to 0xFE, 0xFF, 0x00.
- Second word 0x0800 (reserved bit set) or 0x0000 (opcode 0) → no mem_we for it, error=1, cpu_rst stays 1; err_clr → IDLE, in_ready=1.
- With WATERBEAR_LOADER_CHECKSUM_EN, corrupt CHK (correct XOR ^ 0x01) → all words written, then error=1 and no done pulse. Without the macro, the same frame minus CHK → done.
- Bytes 0x00,0x5A in IDLE are dropped with no state change. in_valid toggling randomly mid-frame gives results identical to the full-rate frame.
- rst asserted during LO of word 2 → all outputs at reset values immediately. The next frame loads correctly.
